// File: rtl/instruction_set.sv
// Shared types and constants for the z8 memory manager.
//   mem_op_e   : data-port operation codes
//   mm_state_e : manager FSM states
//   CTRL_BANK_SEL_LSB : LSB of the bank-select field inside the control word
package instruction_set;

    typedef enum logic [1:0] {
        MEM_NOP   = 2'd0,
        MEM_READ  = 2'd1,
        MEM_WRITE = 2'd2,
        MEM_SWAP  = 2'd3
    } mem_op_e;

    typedef enum logic {
        MM_CLEAR = 1'b0,
        MM_IDLE  = 1'b1
    } mm_state_e;

    localparam int CTRL_BANK_SEL_LSB = 0;

endpackage

// File: rtl/bank_addr_map.sv
// Logical-to-physical data address translation.
// Optional feature macro: MEMMGR_BOUNDS_CHECK_EN
//   defined   : addresses >= COMMON_DEPTH raise out_of_range
//   undefined : address is folded modulo COMMON_DEPTH, out_of_range = 0
// Ports:
//   addr         in  logical data address
//   bank_sel     in  currently selected bank
//   is_bank      out address falls in the bank window
//   phys_index   out index into banks[] (is_bank) or common[] (otherwise)
//   out_of_range out address outside the common region (bounds build only)
module bank_addr_map #(
    parameter int WORD_W       = 8,
    parameter int COMMON_DEPTH = 64,
    parameter int NUM_BANKS    = 4,
    parameter int BANK_WORDS   = 4,
    parameter int WIN_BASE     = 8,
    parameter int SEL_W        = $clog2(NUM_BANKS),
    parameter int IDX_W        = 6
) (
    input  logic [WORD_W-1:0] addr,
    input  logic [SEL_W-1:0]  bank_sel,
    output logic              is_bank,
    output logic [IDX_W-1:0]  phys_index,
    output logic              out_of_range
);

    int unsigned log_addr;
    int unsigned idx;

    always_comb begin
        log_addr = 32'(addr);
`ifdef MEMMGR_BOUNDS_CHECK_EN
        out_of_range = (log_addr >= COMMON_DEPTH);
`else
        out_of_range = 1'b0;
        log_addr     = log_addr % COMMON_DEPTH;
`endif
        // Window test is done on the folded address so wrapped accesses
        // land in the same place as their in-range alias.
        is_bank = (log_addr >= WIN_BASE) && (log_addr < WIN_BASE + BANK_WORDS);
        if (is_bank) begin
            idx = 32'(bank_sel) * BANK_WORDS + (log_addr - WIN_BASE);
        end else begin
            idx = log_addr;
        end
        phys_index = IDX_W'(idx);
    end

endmodule

// File: rtl/banked_memory_manager.sv
// Data/program memory manager for the z8 core.
// Data RAM: handshaked port with registered read (latency 1) and atomic swap,
// an N-way bank window selected by the control register, and a post-reset
// clear engine that zeroes one data word per cycle. Program RAM is written
// at runtime through prog_we and read combinationally at pc.
// Optional feature macro: MEMMGR_BOUNDS_CHECK_EN (sticky err on accesses
// beyond the common region; otherwise addresses wrap and err is 0).
// Ports:
//   clk, reset            clock, async active-high reset
//   pc / current_instruction  fetch address / prog_mem[pc] (0 beyond depth)
//   req, op, addr, write_data request side, accepted on req && ready
//   ready, rvalid, read_data  response side
//   prog_we, prog_addr, prog_wdata  program RAM write port
//   bank_sel, bank_view   selected bank and its contents (word 0 in LSBs)
//   err                   sticky out-of-range flag
//
// state    | meaning
// ---------+----------------------------------------------------------
// MM_CLEAR | zeroing common[] then banks[], one word per cycle, ready=0
// MM_IDLE  | serving requests, ready=1
module banked_memory_manager
    import instruction_set::*;
#(
    parameter int WORD_W       = 8,
    parameter int INSTR_W      = 16,
    parameter int PROG_DEPTH   = 256,
    parameter int COMMON_DEPTH = 64,
    parameter int NUM_BANKS    = 4,
    parameter int BANK_WORDS   = 4,
    parameter int WIN_BASE     = 8,
    parameter int CTRL_ADDR    = 63
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [WORD_W-1:0]                  pc,
    output logic [INSTR_W-1:0]                 current_instruction,
    input  logic                               req,
    input  logic [1:0]                         op,
    input  logic [WORD_W-1:0]                  addr,
    input  logic [WORD_W-1:0]                  write_data,
    output logic                               ready,
    output logic                               rvalid,
    output logic [WORD_W-1:0]                  read_data,
    input  logic                               prog_we,
    input  logic [$clog2(PROG_DEPTH)-1:0]      prog_addr,
    input  logic [INSTR_W-1:0]                 prog_wdata,
    output logic [$clog2(NUM_BANKS)-1:0]       bank_sel,
    output logic [BANK_WORDS*WORD_W-1:0]       bank_view,
    output logic                               err
);

    localparam int SEL_W      = $clog2(NUM_BANKS);
    localparam int BANK_TOTAL = NUM_BANKS * BANK_WORDS;
    localparam int CLR_TOTAL  = COMMON_DEPTH + BANK_TOTAL;
    localparam int CLR_W      = $clog2(CLR_TOTAL);
    localparam int CMN_IW     = $clog2(COMMON_DEPTH);
    localparam int BNK_IW     = $clog2(BANK_TOTAL);
    localparam int IDX_W      = (CMN_IW > BNK_IW) ? CMN_IW : BNK_IW;
    localparam int PROG_AW    = $clog2(PROG_DEPTH);

    logic [WORD_W-1:0]  common_q   [COMMON_DEPTH];
    logic [WORD_W-1:0]  banks_q    [BANK_TOTAL];
    logic [INSTR_W-1:0] prog_mem_q [PROG_DEPTH];

    mm_state_e         state_q, state_d;
    logic [CLR_W-1:0]  clr_cnt_q, clr_cnt_d;
    logic              ready_q, ready_d;
    logic              rvalid_q, rvalid_d;
    logic [WORD_W-1:0] read_data_q, read_data_d;
    logic [SEL_W-1:0]  bank_sel_q, bank_sel_d;

    logic              map_is_bank;
    logic [IDX_W-1:0]  map_idx;
    logic              map_oor;

    logic              cmn_we, bnk_we;
    logic [CMN_IW-1:0] cmn_idx;
    logic [BNK_IW-1:0] bnk_idx;
    logic [WORD_W-1:0] cmn_wd, bnk_wd;

    mem_op_e op_e;
    logic    accept;
    logic    op_reads;
    logic    op_writes;

    assign op_e      = mem_op_e'(op);
    assign accept    = req && ready_q;
    assign op_reads  = (op_e == MEM_READ) || (op_e == MEM_SWAP);
    assign op_writes = (op_e == MEM_WRITE) || (op_e == MEM_SWAP);

    bank_addr_map #(
        .WORD_W       (WORD_W),
        .COMMON_DEPTH (COMMON_DEPTH),
        .NUM_BANKS    (NUM_BANKS),
        .BANK_WORDS   (BANK_WORDS),
        .WIN_BASE     (WIN_BASE),
        .SEL_W        (SEL_W),
        .IDX_W        (IDX_W)
    ) u_map (
        .addr         (addr),
        .bank_sel     (bank_sel_q),
        .is_bank      (map_is_bank),
        .phys_index   (map_idx),
        .out_of_range (map_oor)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= MM_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            MM_CLEAR: begin
                if (clr_cnt_q == CLR_W'(CLR_TOTAL - 1)) begin
                    state_d   = MM_IDLE;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + CLR_W'(1);
                end
            end
            MM_IDLE: begin
                state_d = MM_IDLE;
            end
        endcase
    end

    // Output / datapath control
    always_comb begin
        ready_d     = (state_d == MM_IDLE);
        rvalid_d    = 1'b0;
        read_data_d = read_data_q;
        bank_sel_d  = bank_sel_q;
        cmn_we      = 1'b0;
        cmn_idx     = '0;
        cmn_wd      = '0;
        bnk_we      = 1'b0;
        bnk_idx     = '0;
        bnk_wd      = '0;

        if (state_q == MM_CLEAR) begin
            // Common region first, then the banks, shared with the access port.
            if (32'(clr_cnt_q) < COMMON_DEPTH) begin
                cmn_we  = 1'b1;
                cmn_idx = CMN_IW'(clr_cnt_q);
            end else begin
                bnk_we  = 1'b1;
                bnk_idx = BNK_IW'(32'(clr_cnt_q) - COMMON_DEPTH);
            end
        end else if (accept) begin
            if (map_oor) begin
                if (op_reads) begin
                    rvalid_d    = 1'b1;
                    read_data_d = '0;
                end
            end else begin
                if (op_reads) begin
                    rvalid_d    = 1'b1;
                    read_data_d = map_is_bank ? banks_q[map_idx[BNK_IW-1:0]]
                                              : common_q[map_idx[CMN_IW-1:0]];
                end
                if (op_writes) begin
                    if (map_is_bank) begin
                        bnk_we  = 1'b1;
                        bnk_idx = map_idx[BNK_IW-1:0];
                        bnk_wd  = write_data;
                    end else begin
                        cmn_we  = 1'b1;
                        cmn_idx = map_idx[CMN_IW-1:0];
                        cmn_wd  = write_data;
                        // The control word lives in common[] too, so a read
                        // of CTRL_ADDR returns what was last written there.
                        if (32'(map_idx) == CTRL_ADDR) begin
                            bank_sel_d = write_data[CTRL_BANK_SEL_LSB +: SEL_W];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_q     <= 1'b0;
            rvalid_q    <= 1'b0;
            read_data_q <= '0;
            bank_sel_q  <= '0;
        end else begin
            ready_q     <= ready_d;
            rvalid_q    <= rvalid_d;
            read_data_q <= read_data_d;
            bank_sel_q  <= bank_sel_d;
        end
    end

`ifdef MEMMGR_BOUNDS_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if ((state_q == MM_IDLE) && accept && map_oor && (op_e != MEM_NOP)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Storage arrays carry no reset; the clear engine zeroes data storage
    // and program RAM deliberately survives reset.
    always_ff @(posedge clk) begin
        if (cmn_we) begin
            common_q[cmn_idx] <= cmn_wd;
        end
        if (bnk_we) begin
            banks_q[bnk_idx] <= bnk_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (prog_we) begin
            prog_mem_q[prog_addr] <= prog_wdata;
        end
    end

    always_comb begin
        current_instruction = '0;
        if (32'(pc) < PROG_DEPTH) begin
            current_instruction = prog_mem_q[pc[PROG_AW-1:0]];
        end
    end

    always_comb begin
        bank_view = '0;
        for (int i = 0; i < BANK_WORDS; i++) begin
            bank_view[i*WORD_W +: WORD_W] = banks_q[BNK_IW'(32'(bank_sel_q) * BANK_WORDS + i)];
        end
    end

    assign ready     = ready_q;
    assign rvalid    = rvalid_q;
    assign read_data = read_data_q;
    assign bank_sel  = bank_sel_q;

endmodule

// File: tb/tb_banked_memory_manager.sv
module tb_banked_memory_manager;
    import instruction_set::*;

    localparam int CD   = 64;
    localparam int NB   = 4;
    localparam int BW   = 4;
    localparam int WB   = 8;
    localparam int CTRL = 63;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  pc = '0;
    logic [15:0] current_instruction;
    logic        req = 1'b0;
    logic [1:0]  op = '0;
    logic [7:0]  addr = '0;
    logic [7:0]  write_data = '0;
    logic        ready;
    logic        rvalid;
    logic [7:0]  read_data;
    logic        prog_we = 1'b0;
    logic [7:0]  prog_addr = '0;
    logic [15:0] prog_wdata = '0;
    logic [1:0]  bank_sel;
    logic [31:0] bank_view;
    logic        err;

    int checks = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    logic [7:0] m_common[CD];
    logic [7:0] m_banks[NB*BW];
    int         m_sel;
    logic       m_err;

    banked_memory_manager dut (
        .clk                 (clk),
        .reset               (reset),
        .pc                  (pc),
        .current_instruction (current_instruction),
        .req                 (req),
        .op                  (op),
        .addr                (addr),
        .write_data          (write_data),
        .ready               (ready),
        .rvalid              (rvalid),
        .read_data           (read_data),
        .prog_we             (prog_we),
        .prog_addr           (prog_addr),
        .prog_wdata          (prog_wdata),
        .bank_sel            (bank_sel),
        .bank_view           (bank_view),
        .err                 (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: every rvalid pulse consumes one expected value.
    always @(negedge clk) begin
        if (!reset && rvalid) begin
            if (exp_q.size() == 0) begin
                chk("rvalid_without_request", rvalid, 1'b0);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                chk("read_data", read_data, e);
            end
        end
    end

    function automatic void model_map(input logic [7:0] a, output bit oor,
                                      output bit in_bank, output int idx);
        int la;
        la = int'(a);
`ifdef MEMMGR_BOUNDS_CHECK_EN
        oor = (la >= CD);
`else
        oor = 1'b0;
        la  = la % CD;
`endif
        in_bank = (la >= WB) && (la < WB + BW);
        idx     = in_bank ? (m_sel * BW + la - WB) : la;
    endfunction

    task automatic access(input logic [1:0] o, input logic [7:0] a, input logic [7:0] d);
        bit oor, ib;
        int idx;
        logic [7:0] old;
        bit rd, wr;
        rd = (o == MEM_READ) || (o == MEM_SWAP);
        wr = (o == MEM_WRITE) || (o == MEM_SWAP);
        chk("ready_at_issue", ready, 1'b1);
        model_map(a, oor, ib, idx);
        if (o != MEM_NOP) begin
            if (oor) begin
                m_err = 1'b1;
                if (rd) exp_q.push_back(8'h00);
            end else begin
                old = ib ? m_banks[idx] : m_common[idx];
                if (rd) exp_q.push_back(old);
                if (wr) begin
                    if (ib) m_banks[idx] = d;
                    else begin
                        m_common[idx] = d;
                        if (idx == CTRL) m_sel = int'(d[1:0]);
                    end
                end
            end
        end
        req = 1'b1; op = o; addr = a; write_data = d;
        @(posedge clk); #1;
        req = 1'b0; op = MEM_NOP;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        exp_q.delete();
        for (int i = 0; i < CD; i++) m_common[i] = '0;
        for (int i = 0; i < NB*BW; i++) m_banks[i] = '0;
        m_sel = 0;
        m_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", ready, 1'b0);
        chk("reset_rvalid", rvalid, 1'b0);
        chk("reset_read_data", read_data, 8'h00);
        chk("reset_bank_sel", bank_sel, 2'd0);
        chk("reset_err", err, 1'b0);
        reset = 1'b0;
    endtask

    task automatic wait_ready(input string nm, input int expected);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (ready) done = 1'b1;
        end
        chk(nm, n, expected);
        @(posedge clk); #1;
    endtask

    task automatic check_view();
        logic [31:0] v;
        for (int i = 0; i < BW; i++) v[i*8 +: 8] = m_banks[m_sel*BW + i];
        chk("bank_view", bank_view, v);
        chk("bank_sel", bank_sel, m_sel[1:0]);
        chk("err", err, m_err);
    endtask

    initial begin
        // Power-up clear, read of a cleared word
        apply_reset();
        wait_ready("clear_cycles", CD + NB*BW);
        access(MEM_READ, 8'd5, 8'h00);

        // Bank switching
        access(MEM_WRITE, 8'd9, 8'hA5);
        access(MEM_WRITE, 8'(CTRL), 8'h02);
        chk("bank_sel_after_ctrl", bank_sel, 2'd2);
        access(MEM_READ, 8'd9, 8'h00);
        access(MEM_WRITE, 8'(CTRL), 8'h00);
        access(MEM_READ, 8'd9, 8'h00);
        chk("bank_view_word1", bank_view[15:8], 8'hA5);
        access(MEM_READ, 8'(CTRL), 8'h00);

        // Swap, then read back the new value
        access(MEM_WRITE, 8'd20, 8'h11);
        access(MEM_SWAP, 8'd20, 8'h22);
        access(MEM_READ, 8'd20, 8'h00);

        // Program RAM: same-cycle fetch sees the old word
        prog_we = 1'b1; prog_addr = 8'd3; prog_wdata = 16'h1234;
        @(posedge clk); #1;
        prog_wdata = 16'hBEEF; pc = 8'd3;
        chk("fetch_old_word", current_instruction, 16'h1234);
        @(posedge clk); #1;
        prog_we = 1'b0;
        chk("fetch_new_word", current_instruction, 16'hBEEF);

        // Out-of-range logical address
        access(MEM_WRITE, 8'd70, 8'h5A);
        access(MEM_READ, 8'd6, 8'h00);
        access(MEM_READ, 8'd70, 8'h00);
        check_view();

        // Randomized traffic against the reference model
        for (int it = 0; it < 400; it++) begin
            int r;
            logic [7:0] a;
            r = $urandom_range(0, 19);
            if (r == 0) begin
                @(posedge clk); #1;
            end else begin
                if (r < 12)      a = 8'($urandom_range(0, 15));
                else if (r < 14) a = 8'(CTRL);
                else if (r < 17) a = 8'($urandom_range(0, CD-1));
                else             a = 8'($urandom_range(0, 255));
                access(2'($urandom_range(0, 3)), a, 8'($urandom));
                check_view();
            end
        end

        // Requests and program writes during clear; reset mid-clear
        apply_reset();
        repeat (30) @(posedge clk);
        #1;
        req = 1'b1; op = MEM_WRITE; addr = 8'd5; write_data = 8'hFF;
        prog_we = 1'b1; prog_addr = 8'd7; prog_wdata = 16'h7777;
        @(posedge clk); #1;
        prog_we = 1'b0;
        op = MEM_READ;
        @(posedge clk); #1;
        req = 1'b0; op = MEM_NOP;
        chk("ready_mid_clear", ready, 1'b0);
        apply_reset();
        wait_ready("clear_cycles_after_restart", CD + NB*BW);
        access(MEM_READ, 8'd5, 8'h00);
        access(MEM_READ, 8'd20, 8'h00);
        pc = 8'd7;
        #1;
        chk("prog_write_during_clear", current_instruction, 16'h7777);
        check_view();

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/banked_memory_manager.md
Name: banked_memory_manager

Overview:
Parametrised data/program memory manager for the z8 core.
- Data RAM has a handshaked port with registered read and an atomic swap op.
- An N-way bank-switched window is selected by a field of the control register.
- Program RAM is loaded at runtime through a write port, not a file.
- A post-reset clear engine zeroes data storage one word per cycle.

Parameters:
WORD_W, 8, data word width; also logical address width
INSTR_W, 16, instruction width
PROG_DEPTH, 256, program RAM words; power of 2, at most 2**WORD_W
COMMON_DEPTH, 64, unbanked data words
NUM_BANKS, 4, number of banks; at least 2, power of 2
BANK_WORDS, 4, words per bank
WIN_BASE, 8, logical base of the bank window; WIN_BASE+BANK_WORDS <= COMMON_DEPTH
CTRL_ADDR, 63, logical address of the control register (common region, outside window)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
pc  in  WORD_W  fetch address
current_instruction  out  INSTR_W  prog_mem[pc], combinational
req  in  1  data request valid
op  in  2  MEM_NOP / MEM_READ / MEM_WRITE / MEM_SWAP
addr  in  WORD_W  logical data address
write_data  in  WORD_W  write or swap data
ready  out  1  request accepted when req&&ready
rvalid  out  1  rdata valid, one-cycle pulse
read_data  out  WORD_W  read/swap result
prog_we  in  1  program RAM write strobe
prog_addr  in  $clog2(PROG_DEPTH)  program write address
prog_wdata  in  INSTR_W  program write data
bank_sel  out  $clog2(NUM_BANKS)  ctrl[SEL_W-1:0]
bank_view  out  BANK_WORDS*WORD_W  selected bank contents, word 0 in LSBs, combinational
err  out  1  sticky out-of-range flag

Behaviour:
- Storage: common[COMMON_DEPTH] and banks[NUM_BANKS*BANK_WORDS].
- Address map: logical addr in [WIN_BASE, WIN_BASE+BANK_WORDS) maps to banks[bank_sel*BANK_WORDS + addr-WIN_BASE]. Otherwise maps to common[addr].
- Reset values: FSM=CLEAR, clear counter=0, ready=0, rvalid=0, read_data=0, err=0.
- FSM CLEAR: each cycle zero one physical word (common first, then banks). Counter runs 0..COMMON_DEPTH+NUM_BANKS*BANK_WORDS-1; at the last word go to IDLE. ready=0 throughout; req ignored.
- FSM IDLE: ready=1 (registered; high the cycle after the last clear write).
- Reset asserted mid-CLEAR or mid-access restarts CLEAR at counter 0. An in-flight rvalid is dropped.
- MEM_READ accepted at edge N: read_data valid and rvalid=1 for the cycle after edge N (latency 1).
- MEM_WRITE accepted at edge N: storage updated at edge N, rvalid stays 0.
- MEM_SWAP: read_data returns the old value with latency 1 and the new value is written at the same edge; atomic, no stall.
- MEM_NOP or req=0: no effect. read_data holds its last value when rvalid=0.
- Back-to-back accepts every cycle are allowed. A read after a write to the same address returns the new data.
- Writes to CTRL_ADDR update bank_sel at that edge. The next accepted access uses the new bank.
- prog_we writes prog_mem at the edge in any FSM state, including CLEAR. Fetch of the same address in that cycle returns the old value. prog_mem is not cleared by reset.
- pc >= PROG_DEPTH: current_instruction = 0.

Optional Feature:
MEMMGR_BOUNDS_CHECK_EN
- Defined: logical addr >= COMMON_DEPTH is out-of-range. Writes are ignored. Reads/swaps return 0 with rvalid still pulsed. err is set and stays sticky until reset.
- Undefined: addr is taken modulo COMMON_DEPTH. err is tied to 0.

Decomposition:
- Package instruction_set: mem_op_e enum (MEM_NOP=0, MEM_READ=1, MEM_WRITE=2, MEM_SWAP=3), CTRL_BANK_SEL_LSB, mm_state_e {MM_CLEAR, MM_IDLE}.
- Sub-module bank_addr_map: combinational logical-to-physical mapping. Outputs are is_bank, phys_index and out_of_range.

Test Plan:
- Reset pulse -> ready=0 for exactly 80 cycles (64+16 at defaults), then 1. A read of addr 5 then returns 0 with rvalid one cycle after accept.
- Write 0xA5 to addr 9 (bank 0). Write ctrl 63=0x02 -> bank_sel=2. Read 9 -> 0x00. Write ctrl 0x00, read 9 -> 0xA5. bank_view[15:8]=0xA5 while bank 0 is selected.
- addr 20=0x11, then SWAP addr 20 with 0x22 -> read_data=0x11, rvalid=1. Next read -> 0x22.
- prog_we addr 3=0xBEEF with pc=3 -> current_instruction is old value that cycle, 0xBEEF the next.
- Reset asserted at clear count 30 -> count restarts at 0 and ready rises 80 cycles after deassert.
- With MEMMGR_BOUNDS_CHECK_EN: write addr 70 -> common[6] unchanged, err=1, read 70 returns 0. Without it: write addr 70 lands in common[6].
